baccarat_bet_controller: RTL
============================

Name: baccarat_bet_controller

Overview:
- Sequences the betting side of a baccarat round: accepts a wager from the switches, validates it against the bank, holds the bet while the card state machine plays, then settles the balance from the win lights.
- Drives betenabled and updatebalanceenable into the datapath.
- Owns the 8-bit balance register that the datapath displays.
- Sits between the switch/KEY inputs, statemachine (result) and datapath (display).

Parameters:
- INIT_BALANCE, 50, balance loaded on reset (must be 1..255).
- TIE_PAYOUT, 8, multiplier applied to a winning tie bet (1..8).

Ports:
- slow_clock  input  1  single clock (KEY[0] step clock); all state changes on rising edge.
- reset  input  1  synchronous, active-high; sampled on rising edge of slow_clock.
- place_bet  input  1  request to place the wager on SW; level sampled in IDLE only.
- bet_amount  input  8  wager in credits (SW[7:0]).
- bet_type  input  2  00 player, 01 banker, 10 tie, 11 illegal (SW[9:8]).
- round_done  input  1  statemachine indicates win lights are final; sampled in LOCKED only.
- player_win  input  1  player win light.
- dealer_win  input  1  dealer win light; both high = tie.
- balance  output  8  current bank.
- bet_latched  output  8  wager held for the current round.
- betenabled  output  1  high while a round is in progress; switches are ignored.
- updatebalanceenable  output  1  one-cycle pulse during settlement.
- bet_error  output  1  one-cycle pulse on rejected wager.
- game_over  output  1  balance reached 0; latched until reset.

Behaviour:
- All outputs are registered.
- Reset values: balance=INIT_BALANCE, bet_latched=0, betenabled=0, updatebalanceenable=0, bet_error=0, game_over=0, state=IDLE.
- Reset has priority over every other input in every state, including mid-round; the bet is forfeited without settlement.
- IDLE, place_bet=1:
  - A wager is valid iff bet_amount!=0, bet_amount<=balance and bet_type!=11.
  - Valid wager: latch bet_amount and bet_type; next state LOCKED; betenabled=1 from the next cycle.
  - Invalid wager: bet_error=1 for exactly one cycle; stay in IDLE; balance unchanged.
- LOCKED:
  - betenabled=1.
  - place_bet, bet_amount and bet_type are ignored.
  - On round_done=1: latch the outcome; next state SETTLE.
  - Outcome decode: player only = P, dealer only = B, both = T, neither = push.
- SETTLE (exactly one cycle):
  - updatebalanceenable=1; betenabled=1.
  - The new balance is written on the edge that leaves SETTLE.
- Settlement rules:
  - player bet: P -> +bet; B -> -bet; T -> unchanged; push -> unchanged.
  - banker bet: B -> +bet; P -> -bet; T -> unchanged; push -> unchanged.
  - tie bet: T -> +bet*TIE_PAYOUT; P or B -> -bet; push -> unchanged.
- Arithmetic: compute in 12 bits and saturate at 255. Subtraction cannot underflow because bet<=balance is guaranteed at latch.
- After SETTLE:
  - If the new balance is 0, go to BROKE.
  - Otherwise go to IDLE. betenabled drops on the cycle IDLE is entered.
- BROKE:
  - game_over=1; betenabled=0; all inputs ignored; exit only by reset.
- Latency:
  - place_bet accepted -> betenabled high: 1 cycle.
  - round_done -> updatebalanceenable: 1 cycle.
  - round_done -> new balance visible: 2 cycles.
- round_done asserted while in IDLE or SETTLE is ignored.
- place_bet held high across the return to IDLE is accepted as a new request on the first IDLE cycle. This is permitted behaviour.

Test Plan:
- Reset, then place_bet with bet=20, type=player -> betenabled=1 next cycle, bet_latched=20. Then round_done with player_win=1 -> updatebalanceenable pulses 1 cycle, balance=70, state IDLE.
- balance=50, bet=60 type=banker -> bet_error one-cycle pulse, balance 50, betenabled stays 0. Repeat with bet=0, then type=11 -> same response.
- bet=10 type=tie, round_done with both wins -> balance 50+80=130. bet=10 type=player with both wins -> balance unchanged (push).
- balance=200, bet=200 type=tie with tie outcome -> balance saturates at 255.
- balance=50, bet=50 type=banker with player_win=1 -> balance 0, game_over=1; a subsequent place_bet is ignored; reset -> balance 50, game_over=0.
- Reset asserted in LOCKED with bet=30 -> next cycle balance=50, betenabled=0, IDLE. Toggling bet_amount during LOCKED leaves bet_latched unchanged.

Source files
------------

// File: rtl/baccarat_bet_controller_if.sv
// Bet controller signal bundle: switch/statemachine inputs and datapath outputs.
interface baccarat_bet_controller_if;
    logic       place_bet;
    logic [7:0] bet_amount;
    logic [1:0] bet_type;
    logic       round_done;
    logic       player_win;
    logic       dealer_win;
    logic [7:0] balance;
    logic [7:0] bet_latched;
    logic       betenabled;
    logic       updatebalanceenable;
    logic       bet_error;
    logic       game_over;

    // Stimulus side: drives the switches and round result, observes the bank.
    modport master (
        output place_bet, bet_amount, bet_type, round_done, player_win, dealer_win,
        input  balance, bet_latched, betenabled, updatebalanceenable, bet_error, game_over
    );

    // Controller side.
    modport slave (
        input  place_bet, bet_amount, bet_type, round_done, player_win, dealer_win,
        output balance, bet_latched, betenabled, updatebalanceenable, bet_error, game_over
    );
endinterface

// File: rtl/baccarat_bet_controller.sv
// Baccarat betting sequencer: validates a wager, holds it for the round,
// settles the 8-bit bank from the win lights, and latches game over at zero.
module baccarat_bet_controller #(
    parameter int INIT_BALANCE = 50,
    parameter int TIE_PAYOUT   = 8
) (
    input  logic                           slow_clock,
    input  logic                           reset,
    baccarat_bet_controller_if.slave       bus
);

    typedef enum logic [1:0] {IDLE, LOCKED, SETTLE, BROKE} state_t;

    // Outcome encoding is {player_win, dealer_win}.
    localparam logic [1:0] OUT_PUSH   = 2'b00;
    localparam logic [1:0] OUT_BANKER = 2'b01;
    localparam logic [1:0] OUT_PLAYER = 2'b10;
    localparam logic [1:0] OUT_TIE    = 2'b11;

    localparam logic [1:0] BET_PLAYER = 2'b00;
    localparam logic [1:0] BET_BANKER = 2'b01;
    localparam logic [1:0] BET_TIE    = 2'b10;
    localparam logic [1:0] BET_ILLEGAL = 2'b11;

    localparam logic [11:0] TIE_MULT = 12'(TIE_PAYOUT);

    state_t     state_reg, state_next;
    logic [7:0] balance_reg, balance_next;
    logic [7:0] bet_latched_reg, bet_latched_next;
    logic [1:0] bet_type_reg, bet_type_next;
    logic [1:0] outcome_reg, outcome_next;
    logic       betenabled_reg, betenabled_next;
    logic       update_reg, update_next;
    logic       bet_error_reg, bet_error_next;
    logic       game_over_reg, game_over_next;

    logic       bet_valid;
    logic [11:0] balance_ext, bet_ext, settle_sum;
    logic [7:0]  settled_balance;

    assign bet_valid = (bus.bet_amount != 8'd0) &&
                       (bus.bet_amount <= balance_reg) &&
                       (bus.bet_type != BET_ILLEGAL);

    assign balance_ext = {4'd0, balance_reg};
    assign bet_ext     = {4'd0, bet_latched_reg};

    // Settlement arithmetic in 12 bits; losses never underflow since bet <= balance.
    always_comb begin
        settle_sum = balance_ext;
        case (bet_type_reg)
            BET_PLAYER: begin
                if (outcome_reg == OUT_PLAYER)      settle_sum = balance_ext + bet_ext;
                else if (outcome_reg == OUT_BANKER) settle_sum = balance_ext - bet_ext;
            end
            BET_BANKER: begin
                if (outcome_reg == OUT_BANKER)      settle_sum = balance_ext + bet_ext;
                else if (outcome_reg == OUT_PLAYER) settle_sum = balance_ext - bet_ext;
            end
            BET_TIE: begin
                if (outcome_reg == OUT_TIE)         settle_sum = balance_ext + bet_ext * TIE_MULT;
                else if (outcome_reg != OUT_PUSH)   settle_sum = balance_ext - bet_ext;
            end
            default: settle_sum = balance_ext;
        endcase
        settled_balance = (settle_sum > 12'd255) ? 8'hFF : settle_sum[7:0];
    end

    // Next-state and registered-output logic for the betting round.
    always_comb begin
        state_next       = state_reg;
        balance_next     = balance_reg;
        bet_latched_next = bet_latched_reg;
        bet_type_next    = bet_type_reg;
        outcome_next     = outcome_reg;
        betenabled_next  = 1'b0;
        update_next      = 1'b0;
        bet_error_next   = 1'b0;
        game_over_next   = game_over_reg;
        case (state_reg)
            IDLE: begin
                if (bus.place_bet) begin
                    if (bet_valid) begin
                        bet_latched_next = bus.bet_amount;
                        bet_type_next    = bus.bet_type;
                        betenabled_next  = 1'b1;
                        state_next       = LOCKED;
                    end else begin
                        bet_error_next = 1'b1;
                    end
                end
            end
            LOCKED: begin
                betenabled_next = 1'b1;
                if (bus.round_done) begin
                    outcome_next = {bus.player_win, bus.dealer_win};
                    update_next  = 1'b1;
                    state_next   = SETTLE;
                end
            end
            SETTLE: begin
                balance_next = settled_balance;
                if (settled_balance == 8'd0) begin
                    game_over_next = 1'b1;
                    state_next     = BROKE;
                end else begin
                    state_next = IDLE;
                end
            end
            BROKE: begin
                game_over_next = 1'b1;
            end
            default: state_next = IDLE;
        endcase
    end

    // State and output registers; reset overrides everything, forfeiting any open bet.
    always_ff @(posedge slow_clock) begin
        if (reset) begin
            state_reg       <= IDLE;
            balance_reg     <= 8'(INIT_BALANCE);
            bet_latched_reg <= 8'd0;
            bet_type_reg    <= BET_PLAYER;
            outcome_reg     <= OUT_PUSH;
            betenabled_reg  <= 1'b0;
            update_reg      <= 1'b0;
            bet_error_reg   <= 1'b0;
            game_over_reg   <= 1'b0;
        end else begin
            state_reg       <= state_next;
            balance_reg     <= balance_next;
            bet_latched_reg <= bet_latched_next;
            bet_type_reg    <= bet_type_next;
            outcome_reg     <= outcome_next;
            betenabled_reg  <= betenabled_next;
            update_reg      <= update_next;
            bet_error_reg   <= bet_error_next;
            game_over_reg   <= game_over_next;
        end
    end

    assign bus.balance             = balance_reg;
    assign bus.bet_latched         = bet_latched_reg;
    assign bus.betenabled          = betenabled_reg;
    assign bus.updatebalanceenable = update_reg;
    assign bus.bet_error           = bet_error_reg;
    assign bus.game_over           = game_over_reg;

endmodule
